wasm_frame_stack: RTL and testbench
===================================

// Module: wasm_frame_stack
// PURPOSE
//  Parametrised operand stack with an internal call-frame stack for the WASM CPU datapath.
//  - Keeps operands, locals and frame bases in one RAM-backed stack, plus a FRAMES-deep stack of saved frame bases.
//  - Locals are addressed relative to the current frame base. The caller no longer supplies the return tag.
//  - Ops use a valid/ready handshake.
//  - Illegal ops raise a sticky fault and are not committed.
// PARAMETERS
//  WIDTH   32  operand/local word width
//  DEPTH   64  operand stack entries (power of 2)
//  FRAMES  16  max nested calls (saved frame bases)
//  POP_W   4   width of pop_num
//  ALLOC_W 8   width of alloc_size
//  LIDX_W  8   width of local_idx
//  PW = $clog2(DEPTH)+1 (derived pointer width)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        synchronous active-low reset
//  op_vld         in   1        op present on op_* inputs
//  op_rdy         out  1        block can accept op
//  push_num       in   1        push 0/1 word
//  pop_num        in   POP_W    words popped
//  push_data      in   WIDTH    data pushed
//  call           in   1        enter function
//  retu           in   1        return from function
//  alloc_size     in   ALLOC_W  frame size on call (args+locals)
//  local_set      in   1        mem[base+local_idx] <= win_a
//  local_idx      in   LIDX_W   local index, frame-relative
//  local_get_data out  WIDTH    mem[base+local_idx], combinational
//  win_a/b/c      out  WIDTH    mem[top-1/-2/-3], 0 if below stack bottom
//  top_ptr        out  PW       current top (next free slot)
//  frame_base     out  PW       current frame base
//  frame_depth    out  $clog2(FRAMES)+1  saved frames
//  fault          out  1        sticky fault flag
//  fault_code     out  3        cause of first fault
//  clr_fault      in   1        leave FAULT, keep state
// BEHAVIOUR
//  - Reset: top_ptr=0, frame_base=0, frame_depth=0, fault=0, fault_code=0, op_rdy=0. FSM goes to INIT.
//  - FSM INIT -> RUN -> FAULT -> RUN.
//    - INIT writes mem[k]=0 for k=0..DEPTH-1, one entry per cycle, then goes to RUN. op_rdy=1 only in RUN.
//    - A fault in RUN goes to FAULT. clr_fault in FAULT returns to RUN next cycle.
//    - rst_n low in any state, including mid-INIT, restarts INIT at k=0.
//  - Accept = op_vld & op_rdy. All state updates at that clock edge.
//    - Windows, get data and pointers reflect the op from the next cycle. No other latency.
//  - Let P = top_ptr - pop_num, computed at PW+1 bits, no wrap.
//  - Normal op (no call/retu):
//    - top <= P + push_num.
//    - If local_set: mem[base+idx] <= win_a (push ignored).
//    - Else if push_num: mem[P] <= push_data.
//  - call:
//    - Push frame_base onto frame stack.
//    - frame_base <= P (popped args become locals 0..pop_num-1).
//    - top <= P + alloc_size.
//    - New local slots beyond the args are not cleared.
//  - retu:
//    - If push_num: mem[frame_base] <= win_a (return value).
//    - top <= frame_base + push_num.
//    - Pop saved base into frame_base.
//  - Fault checks, in priority order (code):
//    - 1 ILLEGAL: call&retu, or local_set with call|retu.
//    - 2 UNDERFLOW: pop_num > top_ptr - frame_base.
//    - 3 OVERFLOW: new top > DEPTH.
//    - 4 FRAME_OVF: call with frame_depth == FRAMES.
//    - 5 FRAME_UNF: retu with frame_depth == 0.
//    - 6 LOCAL_OOB: local_set with base+idx >= P.
//  - On fault: op accepted but nothing committed. Set fault=1 and latch code.
//    Later ops are blocked (op_rdy=0) until clr_fault. clr_fault clears fault and fault_code.
//  - Boundaries:
//    - Exactly full (top = DEPTH) is legal; only a further push faults.
//    - pop_num = top - base is legal.
//    - clr_fault outside FAULT is ignored.
//  - local_get_data with base+idx >= DEPTH returns 0; this never faults (read-only).
// CONFIGURATION
//  - WFS_HIGH_WATER_EN defined:
//    - Adds output hw_mark [PW] = max top_ptr since reset.
//    - Adds input hw_clr; hw_clr loads hw_mark with the current top_ptr.
//    - hw_mark resets to 0 and updates the cycle after each committed op.
//  - WFS_HIGH_WATER_EN undefined: hw_mark and hw_clr do not exist; no extra logic.
// TESTING
//  - Reset: rst_n low 2 cycles -> op_rdy=0 for exactly DEPTH cycles, then 1; win_a=0, top_ptr=0.
//  - Push 5, push 7, op pop_num=2 push_num=1 data=12 -> top_ptr=1, win_a=12, win_b=0.
//  - Call chain:
//    - Push 3, push 4, call pop_num=2 alloc_size=4 -> frame_base=0, top_ptr=4, local0=3, local1=4.
//    - Push 9, retu push_num=1 -> top_ptr=1, win_a=9, frame_depth=0.
//  - Overflow: fill to DEPTH, push once more -> fault=1, code=3, top_ptr=DEPTH unchanged, op_rdy=0.
//    clr_fault -> op_rdy=1.
//  - Frame limits:
//    - FRAMES+1 nested calls (alloc 0) -> code=4 on the last call.
//    - retu at depth 0 -> code=5.
//  - local_set idx=2 with frame_base=0 and P=2 -> code=6; mem unchanged.

Source files
------------

// File: rtl/wasm_frame_stack.sv
// WASM operand/local stack with saved-frame stack; WFS_HIGH_WATER_EN adds hw_mark/hw_clr.
// Results visible the cycle after accept; op_rdy low during INIT and while a fault is held.
module wasm_frame_stack #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter int FRAMES  = 16,
  parameter int POP_W   = 4,
  parameter int ALLOC_W = 8,
  parameter int LIDX_W  = 8,
  localparam int PW     = $clog2(DEPTH) + 1,
  localparam int FW     = $clog2(FRAMES) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_vld,
  output logic               op_rdy,
  input  logic               push_num,
  input  logic [POP_W-1:0]   pop_num,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               call,
  input  logic               retu,
  input  logic [ALLOC_W-1:0] alloc_size,
  input  logic               local_set,
  input  logic [LIDX_W-1:0]  local_idx,
  output logic [WIDTH-1:0]   local_get_data,
  output logic [WIDTH-1:0]   win_a,
  output logic [WIDTH-1:0]   win_b,
  output logic [WIDTH-1:0]   win_c,
  output logic [PW-1:0]      top_ptr,
  output logic [PW-1:0]      frame_base,
  output logic [FW-1:0]      frame_depth,
  output logic               fault,
  output logic [2:0]         fault_code,
`ifdef WFS_HIGH_WATER_EN
  input  logic               hw_clr,
  output logic [PW-1:0]      hw_mark,
`endif
  input  logic               clr_fault
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FIW = FW - 1;
  localparam int M0  = (PW > POP_W) ? PW : POP_W;
  localparam int M1  = (M0 > LIDX_W) ? M0 : LIDX_W;
  localparam int XW  = ((M1 > ALLOC_W) ? M1 : ALLOC_W) + 2;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FLT} state_t;

  state_t           state;
  logic [AW-1:0]    init_k;
  logic [WIDTH-1:0] mem  [DEPTH];
  logic [PW-1:0]    fstk [FRAMES];

  // All pointer arithmetic is done wide so underflow/overflow never wraps.
  logic [XW-1:0] top_x, base_x, pop_x, p_x, new_top_x, laddr_x;
  logic [2:0]    code;
  logic          acc;
  logic [FIW-1:0] fidx_push, fidx_pop;

  assign top_x     = XW'(top_ptr);
  assign base_x    = XW'(frame_base);
  assign pop_x     = XW'(pop_num);
  assign p_x       = top_x - pop_x;
  assign laddr_x   = base_x + XW'(local_idx);
  assign acc       = op_vld && op_rdy;
  assign fidx_push = frame_depth[FIW-1:0];
  assign fidx_pop  = frame_depth[FIW-1:0] - FIW'(1);

  always_comb begin
    new_top_x = p_x + XW'(push_num);
    if (call)      new_top_x = p_x + XW'(alloc_size);
    else if (retu) new_top_x = base_x + XW'(push_num);
  end

  always_comb begin
    code = 3'd0;
    if ((call && retu) || (local_set && (call || retu)))    code = 3'd1;
    else if (pop_x > top_x - base_x)                        code = 3'd2;
    else if (new_top_x > XW'(DEPTH))                        code = 3'd3;
    else if (call && frame_depth == FW'(FRAMES))            code = 3'd4;
    else if (retu && frame_depth == '0)                     code = 3'd5;
    else if (local_set && laddr_x >= p_x)                   code = 3'd6;
  end

  always_comb begin
    win_a = (top_ptr >= PW'(1)) ? mem[AW'(top_ptr - PW'(1))] : '0;
    win_b = (top_ptr >= PW'(2)) ? mem[AW'(top_ptr - PW'(2))] : '0;
    win_c = (top_ptr >= PW'(3)) ? mem[AW'(top_ptr - PW'(3))] : '0;
    local_get_data = (laddr_x < XW'(DEPTH)) ? mem[AW'(laddr_x)] : '0;
  end

  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (state == S_INIT) begin
      mem_we = 1'b1;
      mem_wa = init_k;
    end else if (state == S_RUN && acc && code == 3'd0) begin
      if (retu) begin
        mem_we = push_num;
        mem_wa = AW'(frame_base);
        mem_wd = win_a;
      end else if (!call && local_set) begin
        mem_we = 1'b1;
        mem_wa = AW'(laddr_x);
        mem_wd = win_a;
      end else if (!call && push_num) begin
        mem_we = 1'b1;
        mem_wa = AW'(p_x);
        mem_wd = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_INIT;
      init_k      <= '0;
      top_ptr     <= '0;
      frame_base  <= '0;
      frame_depth <= '0;
      fault       <= 1'b0;
      fault_code  <= 3'd0;
      op_rdy      <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_k <= init_k + AW'(1);
          if (init_k == AW'(DEPTH - 1)) begin
            state  <= S_RUN;
            op_rdy <= 1'b1;
          end
        end
        S_RUN: begin
          if (acc) begin
            if (code != 3'd0) begin
              state      <= S_FLT;
              op_rdy     <= 1'b0;
              fault      <= 1'b1;
              fault_code <= code;
            end else begin
              top_ptr <= PW'(new_top_x);
              if (call) begin
                fstk[fidx_push] <= frame_base;
                frame_base      <= PW'(p_x);
                frame_depth     <= frame_depth + FW'(1);
              end else if (retu) begin
                frame_base  <= fstk[fidx_pop];
                frame_depth <= frame_depth - FW'(1);
              end
            end
          end
        end
        default: begin
          if (clr_fault) begin
            state      <= S_RUN;
            op_rdy     <= 1'b1;
            fault      <= 1'b0;
            fault_code <= 3'd0;
          end
        end
      endcase
    end
  end

`ifdef WFS_HIGH_WATER_EN
  logic commit_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_q <= 1'b0;
      hw_mark  <= '0;
    end else begin
      commit_q <= (state == S_RUN) && acc && (code == 3'd0);
      if (hw_clr)                              hw_mark <= top_ptr;
      else if (commit_q && top_ptr > hw_mark)  hw_mark <= top_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_wasm_frame_stack.sv
// Directed bench for wasm_frame_stack (default parameters, high-water feature off).
module tb_wasm_frame_stack;
  localparam int WIDTH = 32, DEPTH = 64, FRAMES = 16;
  localparam int PW = $clog2(DEPTH) + 1, FW = $clog2(FRAMES) + 1;

  logic clk = 1'b0;
  logic rst_n, op_vld, op_rdy, push_num, call, retu, local_set, fault, clr_fault;
  logic [3:0] pop_num;
  logic [WIDTH-1:0] push_data, local_get_data, win_a, win_b, win_c;
  logic [7:0] alloc_size, local_idx;
  logic [PW-1:0] top_ptr, frame_base;
  logic [FW-1:0] frame_depth;
  logic [2:0] fault_code;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wasm_frame_stack dut (
    .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op_rdy(op_rdy),
    .push_num(push_num), .pop_num(pop_num), .push_data(push_data),
    .call(call), .retu(retu), .alloc_size(alloc_size),
    .local_set(local_set), .local_idx(local_idx), .local_get_data(local_get_data),
    .win_a(win_a), .win_b(win_b), .win_c(win_c),
    .top_ptr(top_ptr), .frame_base(frame_base), .frame_depth(frame_depth),
    .fault(fault), .fault_code(fault_code), .clr_fault(clr_fault)
  );

  task automatic idle();
    op_vld = 0; push_num = 0; pop_num = 0; push_data = 0; call = 0; retu = 0;
    alloc_size = 0; local_set = 0; clr_fault = 0;
  endtask

  // One op: waits (bounded) for op_rdy, presents for one edge, samples #1 after.
  task automatic do_op(input logic ps, input int pp, input int d, input logic c,
                       input logic r, input int al, input logic ls, input int ix);
    int n = 0;
    @(negedge clk);
    while (!op_rdy && n < 200) begin @(negedge clk); n++; end
    if (!op_rdy) begin
      vecs++; errs++;
      $display("FAIL op_rdy_timeout got %0b want 1", op_rdy);
    end
    push_num = ps; pop_num = 4'(pp); push_data = d; call = c; retu = r;
    alloc_size = 8'(al); local_set = ls; local_idx = 8'(ix); op_vld = 1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic push(input int d);
    do_op(1, 0, d, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_fault();
    @(negedge clk); clr_fault = 1;
    @(posedge clk); #1 clr_fault = 0;
  endtask

  task automatic test_reset();
    int cnt = 0;
    idle(); local_idx = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (op_rdy !== 1'b0) begin errs++; $display("FAIL rst_op_rdy got %0b want 0", op_rdy); end
    @(negedge clk); rst_n = 1;
    while (op_rdy !== 1'b1 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
    vecs++; if (cnt != DEPTH) begin errs++; $display("FAIL init_cycles got %0d want %0d", cnt, DEPTH); end
    vecs++; if (top_ptr !== '0) begin errs++; $display("FAIL rst_top got %0d want 0", top_ptr); end
    vecs++; if (win_a !== '0) begin errs++; $display("FAIL rst_win_a got %0d want 0", win_a); end
    vecs++; if (frame_base !== '0 || frame_depth !== '0) begin errs++; $display("FAIL rst_frame got %0d/%0d want 0/0", frame_base, frame_depth); end
    vecs++; if (fault !== 1'b0 || fault_code !== 3'd0) begin errs++; $display("FAIL rst_fault got %0b/%0d want 0/0", fault, fault_code); end
  endtask

  task automatic test_push_pop();
    push(5); push(7);
    vecs++; if (top_ptr !== 2 || win_a !== 7 || win_b !== 5) begin errs++; $display("FAIL push2 got %0d,%0d,%0d want 2,7,5", top_ptr, win_a, win_b); end
    do_op(1, 2, 12, 0, 0, 0, 0, 0);
    vecs++; if (top_ptr !== 1) begin errs++; $display("FAIL poppush_top got %0d want 1", top_ptr); end
    vecs++; if (win_a !== 12 || win_b !== 0) begin errs++; $display("FAIL poppush_win got %0d,%0d want 12,0", win_a, win_b); end
    do_op(0, 1, 0, 0, 0, 0, 0, 0);
    vecs++; if (top_ptr !== 0 || win_a !== 0) begin errs++; $display("FAIL pop_empty got %0d,%0d want 0,0", top_ptr, win_a); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    push_num = 1; push_data = 33; op_vld = 1;
    @(negedge clk); push_data = 44;
    @(posedge clk); #1; idle();
    vecs++; if (top_ptr !== 2 || win_a !== 44 || win_b !== 33 || win_c !== 0) begin errs++; $display("FAIL b2b got %0d,%0d,%0d,%0d want 2,44,33,0", top_ptr, win_a, win_b, win_c); end
    do_op(0, 2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_call_chain();
    push(3); push(4);
    do_op(0, 2, 0, 1, 0, 4, 0, 0);
    vecs++; if (frame_base !== 0 || top_ptr !== 4 || frame_depth !== 1) begin errs++; $display("FAIL call got %0d,%0d,%0d want 0,4,1", frame_base, top_ptr, frame_depth); end
    local_idx = 0; #1;
    vecs++; if (local_get_data !== 3) begin errs++; $display("FAIL local0 got %0d want 3", local_get_data); end
    local_idx = 1; #1;
    vecs++; if (local_get_data !== 4) begin errs++; $display("FAIL local1 got %0d want 4", local_get_data); end
    local_idx = 200; #1;
    vecs++; if (local_get_data !== 0) begin errs++; $display("FAIL local_far got %0d want 0", local_get_data); end
    push(9);
    do_op(1, 0, 0, 0, 1, 0, 0, 0);
    vecs++; if (top_ptr !== 1 || win_a !== 9 || frame_depth !== 0 || frame_base !== 0) begin errs++; $display("FAIL retu got %0d,%0d,%0d,%0d want 1,9,0,0", top_ptr, win_a, frame_depth, frame_base); end
  endtask

  task automatic test_local_set();
    push(20);
    do_op(0, 0, 0, 0, 0, 0, 1, 0);
    local_idx = 0; #1;
    vecs++; if (local_get_data !== 20 || top_ptr !== 2) begin errs++; $display("FAIL lset got %0d,%0d want 20,2", local_get_data, top_ptr); end
    do_op(0, 0, 0, 0, 0, 0, 1, 2);
    local_idx = 2; #1;
    vecs++; if (fault !== 1 || fault_code !== 6) begin errs++; $display("FAIL loob_code got %0b,%0d want 1,6", fault, fault_code); end
    vecs++; if (local_get_data !== 0 || top_ptr !== 2 || op_rdy !== 0) begin errs++; $display("FAIL loob_state got %0d,%0d,%0b want 0,2,0", local_get_data, top_ptr, op_rdy); end
    clear_fault();
    vecs++; if (fault !== 0 || fault_code !== 0 || op_rdy !== 1) begin errs++; $display("FAIL clr got %0b,%0d,%0b want 0,0,1", fault, fault_code, op_rdy); end
    do_op(0, 0, 0, 1, 1, 0, 0, 0);
    vecs++; if (fault_code !== 1) begin errs++; $display("FAIL illegal got %0d want 1", fault_code); end
    clear_fault();
  endtask

  task automatic test_overflow();
    for (int i = 2; i < DEPTH; i++) push(100 + i);
    vecs++; if (top_ptr !== DEPTH || win_a !== 100 + DEPTH - 1 || fault !== 0) begin errs++; $display("FAIL full got %0d,%0d,%0b want %0d,%0d,0", top_ptr, win_a, fault, DEPTH, 100 + DEPTH - 1); end
    push(1);
    vecs++; if (fault !== 1 || fault_code !== 3 || top_ptr !== DEPTH || op_rdy !== 0) begin errs++; $display("FAIL ovf got %0b,%0d,%0d,%0b want 1,3,%0d,0", fault, fault_code, top_ptr, op_rdy, DEPTH); end
    clear_fault();
    vecs++; if (op_rdy !== 1 || fault !== 0) begin errs++; $display("FAIL ovf_clr got %0b,%0b want 1,0", op_rdy, fault); end
    clear_fault();
    vecs++; if (op_rdy !== 1 || fault !== 0 || top_ptr !== DEPTH) begin errs++; $display("FAIL clr_in_run got %0b,%0b,%0d want 1,0,%0d", op_rdy, fault, top_ptr, DEPTH); end
    for (int i = 0; i < 4; i++) do_op(0, 15, 0, 0, 0, 0, 0, 0);
    do_op(0, 4, 0, 0, 0, 0, 0, 0);
    vecs++; if (top_ptr !== 0 || fault !== 0) begin errs++; $display("FAIL drain got %0d,%0b want 0,0", top_ptr, fault); end
    do_op(0, 1, 0, 0, 0, 0, 0, 0);
    vecs++; if (fault_code !== 2 || top_ptr !== 0) begin errs++; $display("FAIL underflow got %0d,%0d want 2,0", fault_code, top_ptr); end
    clear_fault();
  endtask

  task automatic test_frames();
    for (int i = 0; i < FRAMES; i++) do_op(0, 0, 0, 1, 0, 0, 0, 0);
    vecs++; if (frame_depth !== FRAMES || fault !== 0) begin errs++; $display("FAIL nest got %0d,%0b want %0d,0", frame_depth, fault, FRAMES); end
    do_op(0, 0, 0, 1, 0, 0, 0, 0);
    vecs++; if (fault_code !== 4 || frame_depth !== FRAMES) begin errs++; $display("FAIL frame_ovf got %0d,%0d want 4,%0d", fault_code, frame_depth, FRAMES); end
    clear_fault();
    for (int i = 0; i < FRAMES; i++) do_op(0, 0, 0, 0, 1, 0, 0, 0);
    vecs++; if (frame_depth !== 0 || fault !== 0) begin errs++; $display("FAIL unnest got %0d,%0b want 0,0", frame_depth, fault); end
    do_op(0, 0, 0, 0, 1, 0, 0, 0);
    vecs++; if (fault_code !== 5 || op_rdy !== 0) begin errs++; $display("FAIL frame_unf got %0d,%0b want 5,0", fault_code, op_rdy); end
    clear_fault();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_back_to_back();
    test_call_chain();
    test_local_set();
    test_overflow();
    test_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want done");
    $fatal(1, "timeout");
  end
endmodule
